// File: rtl/linear_weight_update_if.sv
// rtl/linear_weight_update_if.sv - memory handle bundle between the weight-update engine and a memory port
interface mem_handle;
    logic        r_en;
    logic        w_en;
    logic        avail;
    logic        write_through;
    logic        done;
    logic [31:0] ptr;
    logic [31:0] data_store;
    logic [31:0] data_load;
    logic [31:0] region_begin;
    logic [31:0] region_end;

    modport master (
        output r_en, w_en, avail, write_through, ptr, data_store,
        input  data_load, done, region_begin, region_end
    );

    modport slave (
        input  r_en, w_en, avail, write_through, ptr, data_store,
        output data_load, done, region_begin, region_end
    );
endinterface

// File: rtl/linear_weight_update.sv
// rtl/linear_weight_update.sv - in-place SGD step W -= (lr*dW)>>>FRAC_BITS over a 2-D tensor
module linear_weight_update #(
    parameter int FRAC_BITS = 16,
    parameter bit SATURATE  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic [31:0] lr,
    mem_handle.master   g,
    mem_handle.master   w,
    output logic        done,
    output logic        err,
    output logic [31:0] count
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_GHDR = 3'd1;
    localparam logic [2:0] S_WHDR = 3'd2;
    localparam logic [2:0] S_LOAD = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] lr_q, lr_d;
    logic [31:0] g_nd_q, g_nd_d, g_rows_q, g_rows_d, g_cols_q, g_cols_d;
    logic [31:0] w_nd_q, w_nd_d, w_rows_q, w_rows_d;
    logic [31:0] n_q, n_d, k_q, k_d, count_q, count_d;
    logic        g_ren_q, g_ren_d, w_ren_q, w_ren_d, w_wen_q, w_wen_d, w_wt_q, w_wt_d;
    logic        g_got_q, g_got_d, w_got_q, w_got_d;
    logic [31:0] g_ptr_q, g_ptr_d, w_ptr_q, w_ptr_d, w_store_q, w_store_d;
    logic [31:0] g_data_q, g_data_d, w_data_q, w_data_d;

    logic        g_fire, w_rfire, w_wfire, g_got_n, w_got_n;
    logic [63:0] n_full;
    logic signed [63:0] prod, step;
    logic signed [64:0] res;
    logic [31:0] upd;

    // Data words must fit between the 3-word header and region_end, inclusive.
    function automatic logic fits(input logic [31:0] rb, input logic [31:0] re, input logic [63:0] n);
        logic [64:0] room;
        room = {33'd0, re} - {33'd0, rb} - 65'd2;
        return !room[64] && ({1'b0, n} <= room);
    endfunction

    assign g_fire  = g_ren_q & g.done;
    assign w_rfire = w_ren_q & w.done;
    assign w_wfire = w_wen_q & w.done;
    assign n_full  = {32'd0, g_rows_q} * {32'd0, g_cols_q};

    always_comb begin
        prod = $signed({{32{lr_q[31]}}, lr_q}) * $signed({{32{g_data_q[31]}}, g_data_q});
        step = prod >>> FRAC_BITS;
        res  = $signed({{33{w_data_q[31]}}, w_data_q}) - $signed({step[63], step});
        upd  = res[31:0];
        if (SATURATE && (res[64:31] != {34{1'b0}}) && (res[64:31] != {34{1'b1}}))
            upd = res[64] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end

    always_comb begin
        state_d   = state_q;   idx_d     = idx_q;     lr_d      = lr_q;
        g_nd_d    = g_nd_q;    g_rows_d  = g_rows_q;  g_cols_d  = g_cols_q;
        w_nd_d    = w_nd_q;    w_rows_d  = w_rows_q;
        n_d       = n_q;       k_d       = k_q;       count_d   = count_q;
        g_ren_d   = g_ren_q;   w_ren_d   = w_ren_q;   w_wen_d   = w_wen_q;  w_wt_d = w_wt_q;
        g_got_d   = g_got_q;   w_got_d   = w_got_q;
        g_ptr_d   = g_ptr_q;   w_ptr_d   = w_ptr_q;   w_store_d = w_store_q;
        g_data_d  = g_data_q;  w_data_d  = w_data_q;
        g_got_n   = g_got_q | g_fire;
        w_got_n   = w_got_q | w_rfire;

        // Every completed access retires its request and steps the pointer.
        if (g_fire) begin
            g_ren_d = 1'b0;
            g_ptr_d = g_ptr_q + 32'd1;
        end
        if (w_rfire || w_wfire) begin
            w_ren_d = 1'b0;
            w_wen_d = 1'b0;
            w_wt_d  = 1'b0;
            w_ptr_d = w_ptr_q + 32'd1;
        end

        case (state_q)
            S_IDLE: if (go) begin
                state_d = S_GHDR;
                lr_d    = lr;
                idx_d   = 2'd0;
                count_d = 32'd0;
                g_ptr_d = g.region_begin;
                w_ptr_d = w.region_begin;
            end
            S_GHDR: begin
                if (g_fire) begin
                    case (idx_q)
                        2'd0:    g_nd_d   = g.data_load;
                        2'd1:    g_rows_d = g.data_load;
                        default: g_cols_d = g.data_load;
                    endcase
                    idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
                    if (idx_q == 2'd2) state_d = S_WHDR;
                end else if (!g_ren_q) begin
                    g_ren_d = 1'b1;
                end
            end
            S_WHDR: begin
                if (w_rfire) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd0) w_nd_d = w.data_load;
                    if (idx_q == 2'd1) w_rows_d = w.data_load;
                    if (idx_q == 2'd2) begin
                        idx_d = 2'd0;
                        if (g_nd_q != 32'd2 || w_nd_q != 32'd2 ||
                            g_rows_q != w_rows_q || g_cols_q != w.data_load)
                            state_d = S_ERR;
                        else if (n_full == 64'd0)
                            state_d = S_DONE;
                        else if (!fits(g.region_begin, g.region_end, n_full) ||
                                 !fits(w.region_begin, w.region_end, n_full))
                            state_d = S_ERR;
                        else begin
                            n_d     = n_full[31:0];
                            k_d     = 32'd0;
                            state_d = S_LOAD;
                        end
                    end
                end else if (!w_ren_q) begin
                    w_ren_d = 1'b1;
                end
            end
            S_LOAD: begin
                if (g_fire)  g_data_d = g.data_load;
                if (w_rfire) w_data_d = w.data_load;
                if (g_got_n && w_got_n) begin
                    state_d = S_WB;
                    g_got_d = 1'b0;
                    w_got_d = 1'b0;
                    // Point back at the data word just read so the write lands on it.
                    w_ptr_d = w_rfire ? w_ptr_q : w_ptr_q - 32'd1;
                end else begin
                    g_got_d = g_got_n;
                    w_got_d = w_got_n;
                    if (!g_got_n && !g_ren_q) g_ren_d = 1'b1;
                    if (!w_got_n && !w_ren_q) w_ren_d = 1'b1;
                end
            end
            S_WB: begin
                if (w_wfire) begin
                    count_d = count_q + 32'd1;
                    k_d     = k_q + 32'd1;
                    state_d = (k_q + 32'd1 == n_q) ? S_DONE : S_LOAD;
                end else if (!w_wen_q) begin
                    w_wen_d   = 1'b1;
                    w_store_d = upd;
                    w_wt_d    = (k_q == n_q - 32'd1);
                end
            end
            S_DONE, S_ERR: if (!go) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;  idx_q <= 2'd0;     lr_q <= 32'd0;
            g_nd_q <= 32'd0;    g_rows_q <= 32'd0; g_cols_q <= 32'd0;
            w_nd_q <= 32'd0;    w_rows_q <= 32'd0;
            n_q <= 32'd0;       k_q <= 32'd0;      count_q <= 32'd0;
            g_ren_q <= 1'b0;    w_ren_q <= 1'b0;   w_wen_q <= 1'b0;   w_wt_q <= 1'b0;
            g_got_q <= 1'b0;    w_got_q <= 1'b0;
            g_ptr_q <= 32'd0;   w_ptr_q <= 32'd0;  w_store_q <= 32'd0;
            g_data_q <= 32'd0;  w_data_q <= 32'd0;
        end else begin
            state_q <= state_d; idx_q <= idx_d;       lr_q <= lr_d;
            g_nd_q <= g_nd_d;   g_rows_q <= g_rows_d; g_cols_q <= g_cols_d;
            w_nd_q <= w_nd_d;   w_rows_q <= w_rows_d;
            n_q <= n_d;         k_q <= k_d;           count_q <= count_d;
            g_ren_q <= g_ren_d; w_ren_q <= w_ren_d;   w_wen_q <= w_wen_d; w_wt_q <= w_wt_d;
            g_got_q <= g_got_d; w_got_q <= w_got_d;
            g_ptr_q <= g_ptr_d; w_ptr_q <= w_ptr_d;   w_store_q <= w_store_d;
            g_data_q <= g_data_d; w_data_q <= w_data_d;
        end
    end

    assign g.r_en          = g_ren_q;
    assign g.w_en          = 1'b0;
    assign g.avail         = g_ren_q;
    assign g.write_through = 1'b0;
    assign g.ptr           = g_ptr_q;
    assign g.data_store    = 32'd0;

    assign w.r_en          = w_ren_q;
    assign w.w_en          = w_wen_q;
    assign w.avail         = w_ren_q | w_wen_q;
    assign w.write_through = w_wt_q;
    assign w.ptr           = w_ptr_q;
    assign w.data_store    = w_store_q;

    assign done  = (state_q == S_DONE) || (state_q == S_ERR);
    assign err   = (state_q == S_ERR);
    assign count = count_q;
endmodule

// File: tb/tb_linear_weight_update.sv
// tb/tb_linear_weight_update.sv - directed bench for linear_weight_update (saturating and wrapping builds)
module tb_linear_weight_update;
    logic        clk = 1'b0;
    logic        rst, go, load_img;
    logic [31:0] lr;
    logic        done0, err0, done1, err1;
    logic [31:0] count0, count1;

    always #5 clk = ~clk;

    mem_handle g0 (), w0 (), g1 (), w1 ();

    linear_weight_update #(.FRAC_BITS(16), .SATURATE(1'b1)) dut0 (
        .clk(clk), .rst(rst), .go(go), .lr(lr), .g(g0), .w(w0),
        .done(done0), .err(err0), .count(count0));
    linear_weight_update #(.FRAC_BITS(16), .SATURATE(1'b0)) dut1 (
        .clk(clk), .rst(rst), .go(go), .lr(lr), .g(g1), .w(w1),
        .done(done1), .err(err1), .count(count1));

    // Memory ports 0..3 = g0, w0, g1, w1; g tensors at word 0, w tensors at word 8.
    logic [31:0] mem [4][64];
    logic [31:0] img [4][64];
    logic        m_req [4], m_wen [4], m_done [4];
    logic [31:0] m_ptr [4], m_wdata [4], m_rdata [4];
    int          m_cnt [4], m_lat [4];
    logic        wt_log [8];
    int          wr_cnt;
    logic        wen_seen;

    assign m_req[0] = g0.avail & (g0.r_en | g0.w_en);  assign m_wen[0] = g0.w_en;
    assign m_req[1] = w0.avail & (w0.r_en | w0.w_en);  assign m_wen[1] = w0.w_en;
    assign m_req[2] = g1.avail & (g1.r_en | g1.w_en);  assign m_wen[2] = g1.w_en;
    assign m_req[3] = w1.avail & (w1.r_en | w1.w_en);  assign m_wen[3] = w1.w_en;
    assign m_ptr[0] = g0.ptr;  assign m_wdata[0] = g0.data_store;
    assign m_ptr[1] = w0.ptr;  assign m_wdata[1] = w0.data_store;
    assign m_ptr[2] = g1.ptr;  assign m_wdata[2] = g1.data_store;
    assign m_ptr[3] = w1.ptr;  assign m_wdata[3] = w1.data_store;
    assign g0.done = m_done[0];  assign g0.data_load = m_rdata[0];
    assign w0.done = m_done[1];  assign w0.data_load = m_rdata[1];
    assign g1.done = m_done[2];  assign g1.data_load = m_rdata[2];
    assign w1.done = m_done[3];  assign w1.data_load = m_rdata[3];
    assign g0.region_begin = 32'd0;  assign g0.region_end = 32'd63;
    assign w0.region_begin = 32'd8;  assign w0.region_end = 32'd63;
    assign g1.region_begin = 32'd0;  assign g1.region_end = 32'd63;
    assign w1.region_begin = 32'd8;  assign w1.region_end = 32'd63;

    always @(posedge clk) begin
        if (load_img) begin
            wr_cnt   <= 0;
            wen_seen <= 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            m_done[i] <= 1'b0;
            if (load_img) begin
                m_cnt[i] <= 0;
                for (int a = 0; a < 64; a++) mem[i][a] <= img[i][a];
            end else if (!m_req[i] || m_done[i]) begin
                m_cnt[i] <= 0;
            end else if (m_cnt[i] + 1 >= m_lat[i]) begin
                m_done[i]  <= 1'b1;
                m_rdata[i] <= mem[i][m_ptr[i][5:0]];
                m_cnt[i]   <= 0;
                if (m_wen[i]) begin
                    mem[i][m_ptr[i][5:0]] <= m_wdata[i];
                    if (i == 1) begin
                        wt_log[wr_cnt[2:0]] <= w0.write_through;
                        wr_cnt <= wr_cnt + 1;
                    end
                end
            end else begin
                m_cnt[i] <= m_cnt[i] + 1;
            end
            if (i == 1 && !load_img && m_req[1] && m_wen[1]) wen_seen <= 1'b1;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic put(input int which, input int addr, input logic [31:0] val);
        img[which][addr]     = val;
        img[which + 2][addr] = val;
    endtask

    task automatic hdr(input logic [31:0] gr, input logic [31:0] gc,
                       input logic [31:0] wr, input logic [31:0] wc);
        put(0, 0, 32'd2); put(0, 1, gr); put(0, 2, gc);
        put(1, 8, 32'd2); put(1, 9, wr); put(1, 10, wc);
    endtask

    task automatic load();
        load_img = 1'b1;
        @(negedge clk);
        load_img = 1'b0;
    endtask

    task automatic run(input string tag, input logic [31:0] lr_v);
        int t;
        lr = lr_v;
        go = 1'b1;
        for (t = 0; t < 3000 && !(done0 && done1); t++) @(negedge clk);
        chk({tag, "_finished"}, {31'd0, done0 && done1}, 32'd1);
    endtask

    task automatic release_go();
        go = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic load_2x2();
        hdr(32'd2, 32'd2, 32'd2, 32'd2);
        for (int i = 0; i < 4; i++) begin
            put(0, 3 + i, (i + 1) << 16);
            put(1, 11 + i, (i + 5) << 16);
        end
        load();
    endtask

    initial begin
        int t;
        rst = 1'b1; go = 1'b0; lr = 32'd0; load_img = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_lat[i] = 2;
            for (int a = 0; a < 64; a++) img[i][a] = 32'd0;
        end
        repeat (2) @(negedge clk);
        chk("rst_done", {31'd0, done0}, 32'd0);
        chk("rst_err", {31'd0, err0}, 32'd0);
        chk("rst_count", count0, 32'd0);
        chk("rst_enables", {28'd0, g0.r_en, w0.r_en, w0.w_en, w0.avail}, 32'd0);
        chk("rst_wt_ptr", {31'd0, w0.write_through} | w0.ptr | g0.ptr, 32'd0);
        chk("rst_store", w0.data_store, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        load_2x2();
        run("t2x2", 32'h0001_0000);
        for (int i = 0; i < 4; i++) chk("t2x2_w", mem[1][11 + i], 32'h0004_0000);
        chk("t2x2_count", count0, 32'd4);
        chk("t2x2_err", {31'd0, err0}, 32'd0);
        chk("t2x2_hdr_kept", mem[1][9], 32'd2);
        chk("t2x2_writes", wr_cnt, 32'd4);
        chk("t2x2_wt", {28'd0, wt_log[0], wt_log[1], wt_log[2], wt_log[3]}, 32'b0001);
        repeat (3) @(negedge clk);
        chk("hold_done_go_high", {31'd0, done0}, 32'd1);
        chk("hold_count", count0, 32'd4);
        release_go();
        chk("idle_done_low", {31'd0, done0}, 32'd0);
        chk("idle_count_kept", count0, 32'd4);

        hdr(32'd1, 32'd1, 32'd1, 32'd1);
        put(0, 3, 32'hFFFF_FFFD); put(1, 11, 32'd0);
        load();
        run("half", 32'h0000_8000);
        chk("half_floor", mem[1][11], 32'd2);
        release_go();

        put(0, 3, 32'hFFFF_0000); put(1, 11, 32'h7FFF_FF00);
        load();
        run("sat", 32'h0001_0000);
        chk("sat_clamp", mem[1][11], 32'h7FFF_FFFF);
        chk("sat_wrap", mem[3][11], 32'h8000_FF00);
        release_go();

        hdr(32'd3, 32'd2, 32'd2, 32'd2);
        load();
        run("mismatch", 32'h0001_0000);
        chk("mismatch_err", {31'd0, err0}, 32'd1);
        chk("mismatch_done", {31'd0, done0}, 32'd1);
        chk("mismatch_no_write", {31'd0, wen_seen}, 32'd0);
        chk("mismatch_count", count0, 32'd0);
        release_go();
        chk("mismatch_clear", {31'd0, err0}, 32'd0);

        hdr(32'd0, 32'd5, 32'd0, 32'd5);
        load();
        run("empty", 32'h0001_0000);
        chk("empty_err", {31'd0, err0}, 32'd0);
        chk("empty_count", count0, 32'd0);
        release_go();

        for (int pass = 0; pass < 2; pass++) begin
            m_lat[0] = (pass == 0) ? 1 : 3; m_lat[2] = m_lat[0];
            m_lat[1] = (pass == 0) ? 5 : 3; m_lat[3] = m_lat[1];
            hdr(32'd1, 32'd3, 32'd1, 32'd3);
            put(0, 3, 32'h0001_0000); put(0, 4, 32'hFFFE_0000); put(0, 5, 32'h0000_8000);
            put(1, 11, 32'h0003_0000); put(1, 12, 32'h0000_0000); put(1, 13, 32'hFFFF_0000);
            load();
            run("row3", 32'h0001_0000);
            chk("row3_w0", mem[1][11], 32'h0002_0000);
            chk("row3_w1", mem[1][12], 32'h0002_0000);
            chk("row3_w2", mem[1][13], 32'hFFFE_8000);
            chk("row3_count", count0, 32'd3);
            chk("row3_wt", {29'd0, wt_log[0], wt_log[1], wt_log[2]}, 32'b001);
            release_go();
        end

        for (int i = 0; i < 4; i++) m_lat[i] = 2;
        load_2x2();
        lr = 32'h0001_0000;
        go = 1'b1;
        for (t = 0; t < 3000 && !(count0 == 32'd1 && w0.w_en); t++) @(negedge clk);
        chk("rst_mid_reached_wb2", {31'd0, count0 == 32'd1 && w0.w_en}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_enables", {28'd0, g0.r_en, w0.r_en, w0.w_en, w0.avail}, 32'd0);
        chk("rst_mid_idle", {30'd0, done0, err0}, 32'd0);
        chk("rst_mid_count", count0, 32'd0);
        go = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        load_2x2();
        run("rerun", 32'h0001_0000);
        for (int i = 0; i < 4; i++) chk("rerun_w", mem[1][11 + i], 32'h0004_0000);
        chk("rerun_count", count0, 32'd4);
        release_go();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
